register_file: RTL and testbench

- Parametrised multi-register bank for the Hmmm datapath, replacing single standalone registers.
- Provides two combinational read ports and one synchronous write port for the ALU/decoder.
- Provides a tri-state shared-bus port (`data`) with the same read/write semantics as the existing single register.
- Register 0 can optionally be hardwired to zero, matching the Hmmm r0 convention.

---
 rtl/register_file.sv | 71 +++++++
 tb/tb_register_file.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Parametrised register bank: two combinational read ports, one synchronous write port,
// and a tri-state shared-bus port with register-style read/write semantics.
module register_file #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter bit          ZERO_R0  = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [WIDTH-1:0]  rd_a_data,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [WIDTH-1:0]  rd_b_data,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic              write,
   input  logic              read,
   inout  wire  [WIDTH-1:0]  data
);

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];
   logic             wr_we;
   logic             bus_we;
   logic [WIDTH-1:0] bus_rd;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_R0 && (a == '0);
   endfunction

   always_comb begin
      wr_we  = wr_en && !is_zero(wr_addr);
      // Write port wins a same-address collision; the bus value is dropped.
      bus_we = write && !is_zero(bus_addr) && !(wr_en && (wr_addr == bus_addr));
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = '0;
         end
      end else begin
         if (bus_we) regs_d[bus_addr] = data;
         if (wr_we)  regs_d[wr_addr]  = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   always_comb begin
      rd_a_data = regs_q[rd_a_addr];
      if (BYPASS && wr_we && !rst && (rd_a_addr == wr_addr)) rd_a_data = wr_data;
      if (is_zero(rd_a_addr)) rd_a_data = '0;

      rd_b_data = regs_q[rd_b_addr];
      if (BYPASS && wr_we && !rst && (rd_b_addr == wr_addr)) rd_b_data = wr_data;
      if (is_zero(rd_b_addr)) rd_b_data = '0;

      // Bus reads see stored contents only; write-port data is never forwarded here.
      bus_rd = is_zero(bus_addr) ? '0 : regs_q[bus_addr];
   end

   assign data = (read && !write) ? bus_rd : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Random and directed checks of register_file against a behavioural model, for the default
// configuration and an 8-bit, 4-register instance without zero register or bypass.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst, wr_en, write, read;
   logic [3:0]  wr_addr, rd_a_addr, rd_b_addr, bus_addr;
   logic [15:0] wr_data, drv;
   logic        drv_en;
   wire  [15:0] data0;
   wire  [7:0]  data1;
   logic [15:0] a0, b0;
   logic [7:0]  a1, b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m0 [16];
   logic [7:0]  m1 [4];
   logic        live = 1'b0;

   always #5 clk = ~clk;

   // The bench drives the bus whenever the DUT must not.
   assign drv_en = !(read && !write);
   assign data0  = drv_en ? drv : 16'hzzzz;
   assign data1  = drv_en ? drv[7:0] : 8'hzz;

   register_file u_dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_a_addr(rd_a_addr), .rd_a_data(a0), .rd_b_addr(rd_b_addr), .rd_b_data(b0),
      .bus_addr(bus_addr), .write(write), .read(read), .data(data0)
   );

   register_file #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data[7:0]),
      .rd_a_addr(rd_a_addr[1:0]), .rd_a_data(a1), .rd_b_addr(rd_b_addr[1:0]), .rd_b_data(b1),
      .bus_addr(bus_addr[1:0]), .write(write), .read(read), .data(data1)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_rd0(input logic [3:0] a);
      if (a == 4'd0) return 16'h0;
      if (wr_en && !rst && a == wr_addr) return wr_data;
      return m0[a];
   endfunction

   // Model update: bus write first, so a same-address write-port value overwrites it.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) m0[i] = 16'h0;
         for (int i = 0; i < 4; i++) m1[i] = 8'h0;
         live = 1'b1;
      end else begin
         if (write && bus_addr != 4'd0) m0[bus_addr] = drv;
         if (wr_en && wr_addr != 4'd0) m0[wr_addr] = wr_data;
         if (write) m1[bus_addr[1:0]] = drv[7:0];
         if (wr_en) m1[wr_addr[1:0]] = wr_data[7:0];
      end
   end

   initial forever begin
      @(negedge clk);
      if (live) begin
         check("rd_a0", a0, exp_rd0(rd_a_addr));
         check("rd_b0", b0, exp_rd0(rd_b_addr));
         check("rd_a1", {8'h0, a1}, {8'h0, m1[rd_a_addr[1:0]]});
         check("rd_b1", {8'h0, b1}, {8'h0, m1[rd_b_addr[1:0]]});
         if (read && !write) begin
            check("bus0", data0, (bus_addr == 4'd0) ? 16'h0 : m0[bus_addr]);
            check("bus1", {8'h0, data1}, {8'h0, m1[bus_addr[1:0]]});
         end else begin
            check("bus0_released", data0, drv);
            check("bus1_released", {8'h0, data1}, {8'h0, drv[7:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wr_en = 1'b0; write = 1'b0; read = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      wr_addr = 4'd0; wr_data = 16'h0; rd_a_addr = 4'd0; rd_b_addr = 4'd0;
      bus_addr = 4'd0; drv = 16'h0;
      step();
      idle();

      // Preload, then reset with a bus write pending.
      for (int i = 1; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 16'h0100 + 16'(i);
         step();
      end
      idle();
      rst = 1'b1; write = 1'b1; bus_addr = 4'd5; drv = 16'h1234;
      step();
      idle(); rd_a_addr = 4'd5; rd_b_addr = 4'd9;
      #3;
      check("reset_r5", a0, 16'h0000);
      check("reset_r9", b0, 16'h0000);

      // Write port: bypass on dut0, old value on dut1, both visible next cycle.
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h002A; rd_a_addr = 4'd3; rd_b_addr = 4'd3;
      #3;
      check("bypass_b0", b0, 16'h002A);
      check("nobypass_b1", {8'h0, b1}, 16'h0000);
      step();
      idle();
      #3;
      check("wr_lat_a0", a0, 16'h002A);
      check("wr_lat_a1", {8'h0, a1}, 16'h002A);

      // Bus write then bus read.
      write = 1'b1; bus_addr = 4'd5; drv = 16'd42;
      step();
      idle(); rd_a_addr = 4'd5; read = 1'b1;
      #3;
      check("bus_wr_a0", a0, 16'd42);
      check("bus_rd0", data0, 16'd42);
      check("bus_rd1", {8'h0, data1}, 16'd42);
      read = 1'b0; drv = 16'h0F0F;
      #1;
      check("bus_hiz0", data0, 16'h0F0F);

      // Zero register on dut0; ordinary register on dut1.
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      step();
      idle(); rd_a_addr = 4'd0; bus_addr = 4'd0; read = 1'b1;
      #3;
      check("zero_a0", a0, 16'h0000);
      check("zero_bus0", data0, 16'h0000);
      check("nozero_a1", {8'h0, a1}, 16'h00FF);
      check("nozero_bus1", {8'h0, data1}, 16'h00FF);
      read = 1'b0;

      // Collisions: same address, then distinct addresses.
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; write = 1'b1; bus_addr = 4'd7;
      drv = 16'h2222;
      step();
      idle(); rd_a_addr = 4'd7;
      #3;
      check("coll_same_r7", a0, 16'h1111);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; write = 1'b1; bus_addr = 4'd8;
      drv = 16'h2222;
      step();
      idle(); rd_a_addr = 4'd7; rd_b_addr = 4'd8;
      #3;
      check("coll_diff_r7", a0, 16'h1111);
      check("coll_diff_r8", b0, 16'h2222);
      check("coll_diff1_r3", {8'h0, a1}, 16'h0011);
      check("coll_diff1_r0", {8'h0, b1}, 16'h0022);

      // Narrow instance readback, then read and write together.
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00A5;
      step();
      idle(); rd_a_addr = 4'd3;
      #3;
      check("narrow_a5", {8'h0, a1}, 16'h00A5);
      read = 1'b1; write = 1'b1; bus_addr = 4'd3; drv = 16'h005A;
      #1;
      check("rdwr_nodrive0", data0, 16'h005A);
      check("rdwr_nodrive1", {8'h0, data1}, 16'h005A);
      step();
      idle();
      #3;
      check("rdwr_commit0", a0, 16'h005A);
      check("rdwr_commit1", {8'h0, a1}, 16'h005A);

      // Random traffic with frequent address collisions.
      for (int n = 0; n < 3000; n++) begin
         step();
         rst       = ($urandom_range(0, 49) == 0);
         wr_en     = $urandom_range(0, 1) == 1;
         write     = $urandom_range(0, 2) == 0;
         read      = $urandom_range(0, 1) == 1;
         wr_addr   = 4'($urandom);
         wr_data   = 16'($urandom);
         drv       = 16'($urandom);
         rd_a_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
         rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
         bus_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      end
      step();
      idle();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
